// File: rtl/operand_loader_pkg.sv
// Shared types and widths for the operand loader slice.
package operand_loader_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OPC_W  = 4;

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        WAIT_F = 2'd2,
        READY  = 2'd3
    } opl_state_e;

endpackage

// File: rtl/operand_loader_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each rising edge of the debounced level.
module key_debounce #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic clk_rst,
    input  logic btn,
    output logic press
);

    localparam int unsigned          CNT_W    = 20;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             deb;
    logic             deb_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge clk_rst) begin
        if (!clk_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            press <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            deb_d <= deb;
            press <= deb & ~deb_d;
            // Level flips on the DEB_CYCLES-th consecutive differing sample.
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt <= '0;
                deb <= ~deb;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/operand_loader.sv
// Debounced A/B/F operand loader feeding the ALU stage.
// Define OPL_ORDER_CHECK_EN to enforce the A->B->F load order with err reporting.
module operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              clk_rst,
    input  logic              btn_a,
    input  logic              btn_b,
    input  logic              btn_f,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] a_q,
    output logic [DATA_W-1:0] b_q,
    output logic [OPC_W-1:0]  f_q,
    output logic              ld_a,
    output logic              ld_b,
    output logic              ld_f,
    output logic              ready,
    output logic              err
);

    logic press_a;
    logic press_b;
    logic press_f;
    logic take_a;
    logic take_b;
    logic take_f;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
        .clk(clk), .clk_rst(clk_rst), .btn(btn_a), .press(press_a)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
        .clk(clk), .clk_rst(clk_rst), .btn(btn_b), .press(press_b)
    );
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_f (
        .clk(clk), .clk_rst(clk_rst), .btn(btn_f), .press(press_f)
    );

`ifdef OPL_ORDER_CHECK_EN
    opl_state_e state;
    opl_state_e state_nxt;
    logic       reject;

    always_ff @(posedge clk or negedge clk_rst) begin
        if (!clk_rst) begin
            state <= WAIT_A;
            ready <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == READY);
            err   <= err | reject;
        end
    end

    always_comb begin
        state_nxt = state;
        take_a    = 1'b0;
        take_b    = 1'b0;
        take_f    = 1'b0;
        reject    = 1'b0;
        case (state)
            WAIT_A, READY: begin
                take_a = press_a;
                reject = press_b | press_f;
                if (press_a) state_nxt = WAIT_B;
            end
            WAIT_B: begin
                take_b = press_b;
                reject = press_a | press_f;
                if (press_b) state_nxt = WAIT_F;
            end
            WAIT_F: begin
                take_f = press_f;
                reject = press_a | press_b;
                if (press_f) state_nxt = READY;
            end
            default: state_nxt = WAIT_A;
        endcase
    end
`else
    logic [2:0] seen;
    logic [2:0] seen_nxt;

    always_comb begin
        take_a   = press_a;
        take_b   = press_b;
        take_f   = press_f;
        seen_nxt = seen | {take_f, take_b, take_a};
    end

    // A completed set restarts tracking; a lone A load ends the ready window.
    always_ff @(posedge clk or negedge clk_rst) begin
        if (!clk_rst) begin
            seen  <= '0;
            ready <= 1'b0;
        end else if (&seen_nxt) begin
            seen  <= '0;
            ready <= 1'b1;
        end else begin
            seen <= seen_nxt;
            if (take_a) ready <= 1'b0;
        end
    end

    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge clk_rst) begin
        if (!clk_rst) begin
            a_q  <= '0;
            b_q  <= '0;
            f_q  <= '0;
            ld_a <= 1'b0;
            ld_b <= 1'b0;
            ld_f <= 1'b0;
        end else begin
            ld_a <= take_a;
            ld_b <= take_b;
            ld_f <= take_f;
            if (take_a) a_q <= data_in;
            if (take_b) b_q <= data_in;
            if (take_f) f_q <= data_in[OPC_W-1:0];
        end
    end

endmodule
